// File: rtl/rand_pkg.sv
// Shared constants and types for the pseudo-random word source.
package rand_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned SW_W   = 2;

  // Right-shift Galois feedback taps for the 32-bit LFSR.
  localparam logic [WORD_W-1:0] LFSR_TAPS    = 32'h8020_0003;
  // Reset and lock-recovery seed; never zero.
  localparam logic [WORD_W-1:0] DEFAULT_SEED = 32'hACE1_2024;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } rand_state_t;

  // One plain Galois step, without any switch mixing.
  function automatic logic [WORD_W-1:0] galois_step(input logic [WORD_W-1:0] s);
    logic [WORD_W-1:0] r;
    r = s >> 1;
    if (s[0]) begin
      r = r ^ LFSR_TAPS;
    end
    return r;
  endfunction

endpackage

// File: rtl/rand_lfsr_step.sv
// Combinational LFSR next-state function, with optional switch entropy mix.
// Optional feature macro: RAND_SWITCH_MIX_EN (XOR switches into the low bits).
module rand_lfsr_step
  import rand_pkg::*;
(
  input  logic [WORD_W-1:0] lfsr_i,
  input  logic [SW_W-1:0]   switches_i,
  output logic [WORD_W-1:0] nxt_c_o
);

`ifdef RAND_SWITCH_MIX_EN
  // Galois step, then fold the board switches into the two low bits.
  always_comb begin
    nxt_c_o = galois_step(lfsr_i);
    nxt_c_o[SW_W-1:0] = nxt_c_o[SW_W-1:0] ^ switches_i;
  end
`else
  logic unused_switches;
  assign unused_switches = ^switches_i;

  // Pure LFSR sequence; switches have no effect in this build.
  always_comb begin
    nxt_c_o = galois_step(lfsr_i);
  end
`endif

endmodule

// File: rtl/rand_word_src.sv
// Pseudo-random 32-bit word source: tick divider, RUN/HOLD control,
// reseed, lock-up recovery and registered word/strobe outputs.
// Optional feature macro: RAND_SWITCH_MIX_EN (handled in rand_lfsr_step).
module rand_word_src
  import rand_pkg::*;
#(
  parameter int unsigned       WIDTH      = 32,
  parameter int unsigned       DIV_W      = 24,
  parameter int unsigned       UPDATE_DIV = 50000,
  parameter logic [WIDTH-1:0]  SEED       = WIDTH'(DEFAULT_SEED)
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_value,
  input  logic             hold,
  input  logic             step_req,
  input  logic [1:0]       switches,
  output logic [WIDTH-1:0] rand_out,
  output logic             rand_valid,
  output logic             lock_err
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(UPDATE_DIV - 1);

  rand_state_t      state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic             valid_q, valid_d;
  logic             lock_q, lock_d;

  logic [WORD_W-1:0] step_nxt_c;
  logic              do_step_c;
  logic [WIDTH-1:0]  cand_c;

  rand_lfsr_step u_step (
    .lfsr_i     (WORD_W'(lfsr_q)),
    .switches_i (switches),
    .nxt_c_o    (step_nxt_c)
  );

  // Next-state: divider/FSM, then seed-over-step priority, then lock-up check.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    lfsr_d    = lfsr_q;
    valid_d   = 1'b0;
    lock_d    = lock_q;
    do_step_c = 1'b0;
    cand_c    = WIDTH'(step_nxt_c);

    unique case (state_q)
      RUN: begin
        if (hold) begin
          state_d = HOLD;
          div_d   = '0;
        end else if (div_q == DIV_LAST) begin
          div_d     = '0;
          do_step_c = 1'b1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      HOLD: begin
        div_d = '0;
        if (step_req) begin
          do_step_c = 1'b1;
        end
        if (!hold) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        div_d   = '0;
      end
    endcase

    // A reseed wins over any tick or step in the same cycle and freezes the FSM.
    if (seed_load) begin
      state_d   = state_q;
      div_d     = '0;
      do_step_c = 1'b0;
      cand_c    = seed_value;
    end

    if (seed_load || do_step_c) begin
      valid_d = 1'b1;
      if (cand_c == '0) begin
        lfsr_d = SEED;
        lock_d = 1'b1;
      end else begin
        lfsr_d = cand_c;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q <= RUN;
      div_q   <= '0;
      lfsr_q  <= SEED;
      valid_q <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      lfsr_q  <= lfsr_d;
      valid_q <= valid_d;
      lock_q  <= lock_d;
    end
  end

  assign rand_out   = lfsr_q;
  assign rand_valid = valid_q;
  assign lock_err   = lock_q;

endmodule

// File: tb/tb_rand_word_src.sv
// Scoreboard bench for rand_word_src: directed scenarios plus random traffic
// against a cycle-level behavioural model.
module tb_rand_word_src;

  localparam int unsigned DIV  = 4;
  localparam logic [31:0] SEED = 32'h0000_0001;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  typedef struct packed {
    logic        valid;
    logic        lock;
    logic [31:0] word;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        sl;
  logic [31:0] sv;
  logic        hd;
  logic        sr;
  logic [1:0]  sw;
  logic [31:0] rand_out;
  logic        rand_valid;
  logic        lock_err;

  exp_t sb_q[$];
  int   n_checks;
  int   n_fail;

  // Behavioural model state
  logic [31:0] m_word;
  logic        m_lock;
  logic        m_held;
  int          m_cnt;

  rand_word_src #(
    .WIDTH      (32),
    .DIV_W      (24),
    .UPDATE_DIV (DIV),
    .SEED       (SEED)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .seed_load   (sl),
    .seed_value  (sv),
    .hold        (hd),
    .step_req    (sr),
    .switches    (sw),
    .rand_out    (rand_out),
    .rand_valid  (rand_valid),
    .lock_err    (lock_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Next word: halve, and when the dropped bit was 1 fold the taps back in.
  function automatic logic [31:0] ref_next(input logic [31:0] x, input logic [1:0] w);
    logic [31:0] r;
    r = x / 2;
    if (x % 2 == 1) r = r ^ TAPS;
`ifdef RAND_SWITCH_MIX_EN
    r[1:0] = r[1:0] ^ w;
`else
    if (w == 2'b00) r = r;
`endif
    return r;
  endfunction

  // Drive one cycle of inputs and push the model's prediction for the next edge.
  task automatic apply(input logic r, input logic l, input logic [31:0] v,
                       input logic h, input logic s, input logic [1:0] w);
    logic        upd;
    logic [31:0] newv;
    exp_t        e;
    rst = r; sl = l; sv = v; hd = h; sr = s; sw = w;
    upd  = 1'b0;
    newv = '0;
    if (r) begin
      m_word = SEED; m_lock = 1'b0; m_held = 1'b0; m_cnt = 0;
    end else begin
      if (l) begin
        m_cnt = 0; upd = 1'b1; newv = v;
      end else if (!m_held) begin
        if (h) begin
          m_held = 1'b1; m_cnt = 0;
        end else if (m_cnt == DIV - 1) begin
          m_cnt = 0; upd = 1'b1; newv = ref_next(m_word, w);
        end else begin
          m_cnt++;
        end
      end else begin
        if (s) begin
          upd = 1'b1; newv = ref_next(m_word, w);
        end
        if (!h) m_held = 1'b0;
        m_cnt = 0;
      end
      if (upd) begin
        if (newv == 32'h0) begin
          newv = SEED; m_lock = 1'b1;
        end
        m_word = newv;
      end
    end
    e.valid = upd;
    e.lock  = m_lock;
    e.word  = m_word;
    sb_q.push_back(e);
  endtask

  task automatic wait_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic h, input logic [1:0] w);
    repeat (n) begin
      apply(1'b0, 1'b0, 32'h0, h, 1'b0, w);
      wait_edge();
    end
  endtask

  // Monitor: one prediction per cycle, compared at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("sb_valid", {31'h0, rand_valid}, {31'h0, e.valid});
      check("sb_word", rand_out, e.word);
      check("sb_lock", {31'h0, lock_err}, {31'h0, e.lock});
    end
  end

  initial begin
    logic h_r;
    int   r;
    n_checks = 0;
    n_fail   = 0;
    m_word = SEED; m_lock = 1'b0; m_held = 1'b0; m_cnt = 0;

    // Reset and auto-advance sequence
    apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
    wait_edge();
    check("reset_word", rand_out, 32'h0000_0001);
    check("reset_lock", {31'h0, lock_err}, 32'h0);
    idle(4, 1'b0, 2'b00);
    check("auto1", rand_out, 32'h8020_0003);
    idle(4, 1'b0, 2'b00);
    check("auto2", rand_out, 32'hC030_0002);
    idle(4, 1'b0, 2'b00);
    check("auto3", rand_out, 32'h6018_0001);

    // Hold freezes, then single steps
    idle(20, 1'b1, 2'b00);
    check("hold_frozen", rand_out, 32'h6018_0001);
    repeat (3) begin
      apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 2'b00);
      wait_edge();
    end
    check("step3", rand_out, 32'h6C1B_0001);

    // Reseed on a tick cycle drops the tick and restarts the divider
    idle(1, 1'b0, 2'b00);
    idle(3, 1'b0, 2'b00);
    apply(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 2'b00);
    wait_edge();
    check("seed_load", rand_out, 32'h1234_5678);
    idle(3, 1'b0, 2'b00);
    check("seed_no_early", rand_out, 32'h1234_5678);
    idle(1, 1'b0, 2'b00);
    check("seed_next", rand_out, 32'h091A_2B3C);

    // Zero seed triggers lock recovery
    apply(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 2'b00);
    wait_edge();
    check("lock_word", rand_out, SEED);
    check("lock_set", {31'h0, lock_err}, 32'h1);
    idle(10, 1'b0, 2'b00);
    check("lock_sticky", {31'h0, lock_err}, 32'h1);

    // Reset while in HOLD
    idle(3, 1'b1, 2'b00);
    apply(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 2'b00);
    wait_edge();
    check("rst_hold_word", rand_out, SEED);
    check("rst_hold_lock", {31'h0, lock_err}, 32'h0);
    idle(3, 1'b0, 2'b00);
    check("rst_run_wait", rand_out, SEED);
    idle(1, 1'b0, 2'b00);
    check("rst_run_step", rand_out, 32'h8020_0003);

`ifdef RAND_SWITCH_MIX_EN
    apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'b11);
    wait_edge();
    idle(4, 1'b0, 2'b11);
    check("mix_first", rand_out, 32'h8020_0000);
`endif

    // Random traffic against the model
    h_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 199));
      if ($urandom_range(0, 19) == 0) h_r = ~h_r;
      apply(r == 0,
            (r >= 1) && (r <= 6),
            ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom,
            h_r,
            $urandom_range(0, 2) == 0,
            2'($urandom_range(0, 3)));
      wait_edge();
    end
    idle(2, 1'b0, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
